// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: loads Nk key words, then derives one word per
// clock into a 60-word array and serves any round key by index.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0 naturally.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [2:0]   key_len,
    input  logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic [3:0]   nr,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t           state, state_n;
    logic [31:0]      w [60];
    logic [5:0]       i;
    logic [2:0]       j;
    logic [7:0]       rcon;
    logic [3:0]       nk;
    logic [3:0]       nk_sel, nr_sel;
    logic [7:0][31:0] key_al;
    logic             accept, last;
    logic [31:0]      w_prev, w_back, temp;
    logic [3:0][7:0]  sub_w;
    logic [5:0]       base;

    always_comb begin
        nk_sel = 4'd0;
        nr_sel = 4'd0;
        key_al = key;
        if (key_len[2]) begin
            nk_sel = 4'd8;
            nr_sel = 4'd14;
        end else if (key_len[1]) begin
            nk_sel = 4'd6;
            nr_sel = 4'd12;
            key_al = {key[191:0], 64'h0};
        end else if (key_len[0]) begin
            nk_sel = 4'd4;
            nr_sel = 4'd10;
            key_al = {key[127:0], 128'h0};
        end
    end

    assign accept = (state != EXPAND) && start && (key_len != 3'b000);
    assign last   = (state == EXPAND) && (i == {nr, 2'b11});
    assign w_prev = w[i - 6'd1];
    assign w_back = w[i - {2'b00, nk}];

    // SubWord(RotWord(x)) == RotWord(SubWord(x)), so one set of four S-boxes serves both paths.
    aes_sbox u_sbox [3:0] (.a(w_prev), .s(sub_w));

    always_comb begin
        temp = w_prev;
        if (j == 3'd0)
            temp = {sub_w[2], sub_w[1], sub_w[0], sub_w[3]} ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            temp = sub_w;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (accept) state_n = EXPAND;
            EXPAND:     if (last)   state_n = DONE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == EXPAND);
            done  <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 60; k++) w[k] <= 32'h0;
            i    <= 6'd0;
            j    <= 3'd0;
            rcon <= 8'h00;
            nk   <= 4'd0;
            nr   <= 4'd0;
        end else if (accept) begin
            for (int k = 0; k < 8; k++)
                if (4'(k) < nk_sel) w[k] <= key_al[7-k];
            nk   <= nk_sel;
            nr   <= nr_sel;
            i    <= {2'b00, nk_sel};
            j    <= 3'd0;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            w[i] <= w_back ^ temp;
            i    <= i + 6'd1;
            j    <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
            if (j == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    assign base = {rk_idx, 2'b00};

    always_comb begin
        round_key = 128'h0;
        if (rk_idx <= nr)
            round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-expansion vectors.

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic [2:0]   key_len = 3'b000;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] round_key;
    logic [3:0]   nr;
    logic         busy;
    logic         done;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [255:0] key;
        logic [2:0]   len;
        int           cycles;
        logic [3:0]   nr;
        int           pulse_at;
    } run_t;

    typedef struct {
        int           run;
        logic [3:0]   idx;
        logic [127:0] rk;
    } rd_t;

    run_t runs[4];
    rd_t  rds[$];

    aes_key_expand dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .key_len(key_len),
        .rk_idx(rk_idx), .round_key(round_key), .nr(nr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start at the next edge, scramble key/key_len afterwards, count cycles until done.
    task automatic run_one(input run_t r, input string tag);
        int cyc;
        @(negedge clk);
        key = r.key;
        key_len = r.len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = ~r.key;
        key_len = 3'b100;
        check({tag, " busy after start"}, 128'(busy), 128'd1);
        check({tag, " done after start"}, 128'(done), 128'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            start = (r.pulse_at != 0 && cyc == r.pulse_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " cycles to done"}, 128'(cyc), 128'(r.cycles));
        check({tag, " nr"}, 128'(nr), 128'(r.nr));
        check({tag, " busy at done"}, 128'(busy), 128'd0);
    endtask

    task automatic read_checks(input int run, input string tag);
        foreach (rds[k]) begin
            if (rds[k].run == run) begin
                rk_idx = rds[k].idx;
                #1;
                check($sformatf("%s rk[%0d]", tag, rds[k].idx), round_key, rds[k].rk);
            end
        end
    endtask

    initial begin
        run_t r;
        runs[0] = '{256'h2b7e151628aed2a6abf7158809cf4f3c, 3'b001, 40, 4'd10, 10};
        runs[1] = '{256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 3'b010, 46, 4'd12, 0};
        runs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    3'b111, 52, 4'd14, 0};
        runs[3] = '{256'h2b7e151628aed2a6abf7158809cf4f3c, 3'b001, 40, 4'd10, 0};

        rds.push_back('{0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        rds.push_back('{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
        rds.push_back('{0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f});
        rds.push_back('{0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        rds.push_back('{0, 4'd11, 128'h0});
        rds.push_back('{0, 4'd15, 128'h0});
        rds.push_back('{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
        rds.push_back('{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5});
        rds.push_back('{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202});
        rds.push_back('{1, 4'd13, 128'h0});
        rds.push_back('{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781});
        rds.push_back('{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4});
        rds.push_back('{2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde});
        rds.push_back('{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
        rds.push_back('{2, 4'd15, 128'h0});
        rds.push_back('{3, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        rds.push_back('{3, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        rds.push_back('{3, 4'd11, 128'h0});

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        check("reset nr", 128'(nr), 128'd0);
        check("reset round_key", round_key, 128'h0);
        reset = 1'b1;

        // Invalid key length is ignored
        @(negedge clk);
        key = runs[0].key;
        key_len = 3'b000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("keylen0 busy", 128'(busy), 128'd0);
        check("keylen0 done", 128'(done), 128'd0);
        check("keylen0 nr", 128'(nr), 128'd0);

        // 128 (with mid-run start pulse), 192, 256, then 128 back-to-back from DONE
        for (int ri = 0; ri < 4; ri++) begin
            run_one(runs[ri], $sformatf("run%0d", ri));
            read_checks(ri, $sformatf("run%0d", ri));
        end

        // Reset mid-expansion, then a fresh AES-128 run
        @(negedge clk);
        key = runs[0].key;
        key_len = 3'b001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort busy before reset", 128'(busy), 128'd1);
        rk_idx = 4'd0;
        reset = 1'b0;
        #1;
        check("abort busy", 128'(busy), 128'd0);
        check("abort done", 128'(done), 128'd0);
        check("abort nr", 128'(nr), 128'd0);
        check("abort round_key", round_key, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("after release busy", 128'(busy), 128'd0);
        r = runs[0];
        r.pulse_at = 0;
        run_one(r, "restart");
        read_checks(3, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
